conv_kernel_loader: RTL and testbench
=====================================

# conv_kernel_loader

Streams convolution weights from a single-port synchronous weight memory into per-channel kernel slots that feed the spatial convolution core's `kernel_i` / `kernel_valid_i` inputs. It sits directly upstream of the convolution core. Each channel slot holds the KERNEL_SIZE² weights of one (kernel, channel) pair. Consumption is detected through the core's `hold_kernel` handshake. The slot is then refilled with the same channel of the next kernel, wrapping over N_KERNELS indefinitely.

## Interface
- ADDR_WIDTH, 16, weight memory address width
- DATA_WIDTH, 32, weight word width (fixed point, passed through untouched)
- N_CHANNELS, 32, number of channel slots
- N_KERNELS, 32, kernels per layer
- KERNEL_SIZE, 3, kernel side length; slot holds KERNEL_SIZE² words
- BASE_ADDR, 0, address of word 0 of kernel 0, channel 0

- clock_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- enable_i  in  1  allows new slot fills to start
- hold_kernel_i  in  1 x N_CHANNELS (unpacked)  consumer hold per channel
- mem_data_i  in  DATA_WIDTH  read data; valid the cycle after `mem_rd_o`
- mem_rd_o  out  1  memory read strobe
- mem_addr_o  out  ADDR_WIDTH  memory read address
- kernel_valid_o  out  1 x N_CHANNELS (unpacked)  slot c holds a complete, unconsumed kernel
- kernel_o  out  DATA_WIDTH x N_CHANNELS·KERNEL_SIZE² (unpacked)  slot c word i at index c·KERNEL_SIZE²+i
- kernel_index_o  out  clog2(N_KERNELS)+1 x N_CHANNELS  kernel index currently held or being filled in slot c

## Operation
- Memory layout: word i of (kernel k, channel c) is at address BASE_ADDR + (k·N_CHANNELS + c)·KERNEL_SIZE² + i.
  - Computed modulo 2^ADDR_WIDTH.
  - Incremental address arithmetic is allowed; no multiplier is required.
- FSM states: SELECT and FETCH.
- SELECT:
  - If enable_i=1 and any slot is empty (kernel_valid_o[c]=0), register the chosen channel and go to FETCH.
  - Otherwise stay in SELECT.
  - Choice is round-robin: the first empty slot at or after (last filled channel + 1) mod N_CHANNELS.
  - After reset, the search starts at channel 0.
- FETCH:
  - Issue reads for words 0..KERNEL_SIZE²−1 on consecutive cycles, with mem_rd_o=1 during those cycles.
  - Capture mem_data_i into slot word i one cycle after its read.
  - At the edge that captures the last word, set kernel_valid_o[c]=1 and return to SELECT.
  - An in-progress fetch always completes, even if enable_i drops.
- Consumption:
  - Each slot keeps a registered copy of hold_kernel_i[c].
  - Consumption = kernel_valid_o[c]=1 and previous hold=1 and current hold_kernel_i[c]=0 (falling edge of hold while valid).
  - On that edge, clear kernel_valid_o[c] and advance kernel_index_o[c] = (index+1) mod N_KERNELS.
  - A falling edge of hold while valid=0 is ignored.
- Slot words change only while the slot is being filled. They are stable whenever kernel_valid_o[c]=1 or hold_kernel_i[c]=1.
- A slot whose valid clears on edge E is eligible for SELECT no earlier than the edge after E.
- Selection and consumption on the same edge affect different slots only, because a valid slot is never selected.
- The block never writes a slot that is valid.

## Timing
- Reset values: kernel_valid_o all 0, kernel_o all 0, kernel_index_o all 0, mem_rd_o 0, mem_addr_o BASE_ADDR, FSM = SELECT, round-robin pointer 0.
- Reset asserted mid-fetch aborts the fetch immediately. No slot becomes valid from the aborted fetch.
- Let E0 be the SELECT edge:
  - Reads occupy the cycles after E0..E(K²−1).
  - Word i is captured at E(i+2).
  - kernel_valid_o rises at E(K²+1); this is E10 for K=3.
- Back-to-back fills: the next SELECT edge is E(K²+2). Fill period = K²+2 cycles; 11 for K=3.
- Memory read latency is fixed at 1 cycle. There is no backpressure from memory.

## Test plan
- Reset fill: N_CHANNELS=2, N_KERNELS=2, K=3, BASE_ADDR=0, memory word a = a+100, enable_i=1 from first edge after reset.
  - Slot 0 → valid rises 10 edges after first SELECT, kernel_o[0..8]=100..108.
  - Slot 1 → valid rises 11 edges later, kernel_o[9..17]=109..117.
  - mem_rd_o is high for exactly 9 cycles per fill.
- Consume/refill: drive hold_kernel_i[0] 1→0 on slot 0.
  - kernel_valid_o[0] drops at that edge and kernel_index_o[0]=1.
  - Slot 0 refills with 118..126.
  - kernel_o[9..17] stays 109..117 throughout.
- Wrap: consume kernel 1 of channel 1 → refill reads addresses 9..17 again, kernel_index_o[1]=0.
- Hold without valid / no falling edge: hold held at 1 indefinitely → no refill. A hold pulse while the slot is empty → no index change.
- enable_i gating: drop enable_i during FETCH → the current fill completes and is valid. No new SELECT until enable_i=1; mem_rd_o stays 0.
- Reset mid-fetch: assert reset_i at word 4 → all valid 0 and index 0 immediately. After release, the fill restarts from address BASE_ADDR for slot 0.

Source files
------------

// File: rtl/conv_kernel_loader.sv
// Fills per-channel kernel slots from a single-port weight memory and refills a
// slot with the next kernel of the same channel once the convolution core releases it.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   SELECT | idle; picks the next empty slot round-robin when enabled
//   FETCH  | streams K*K reads for the chosen slot, captures data one cycle later
module conv_kernel_loader #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int N_CHANNELS  = 32,
    parameter int N_KERNELS   = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int BASE_ADDR   = 0
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        hold_kernel_i  [N_CHANNELS],
    input  logic [DATA_WIDTH-1:0]       mem_data_i,
    output logic                        mem_rd_o,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    output logic                        kernel_valid_o [N_CHANNELS],
    output logic [DATA_WIDTH-1:0]       kernel_o       [N_CHANNELS*KERNEL_SIZE*KERNEL_SIZE],
    output logic [$clog2(N_KERNELS):0]  kernel_index_o [N_CHANNELS]
);
    localparam int K2   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int ST_W = $clog2(K2 + 1);
    localparam int IX_W = $clog2(N_KERNELS) + 1;
    localparam int WI_W = $clog2(N_CHANNELS * K2);

    typedef enum logic {SELECT, FETCH} state_t;

    state_t                state;
    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       fill_ch;
    logic [CH_W-1:0]       pick;
    logic                  pick_ok;
    logic [ST_W-1:0]       step;
    logic                  hold_q [N_CHANNELS];
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [WI_W-1:0]       wr_idx;

    // First empty slot at or after the round-robin pointer.
    always_comb begin
        int              idx;
        logic [CH_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int j = 0; j < N_CHANNELS; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
            cand = CH_W'(idx);
            if (!pick_ok && !kernel_valid_o[cand]) begin
                pick_ok = 1'b1;
                pick    = cand;
            end
        end
    end

    // Word 0 of (kernel, channel); the truncating cast gives the modulo wrap.
    assign pick_addr = ADDR_WIDTH'(BASE_ADDR +
                       (int'(kernel_index_o[pick]) * N_CHANNELS + int'(pick)) * K2);

    // step counts edges since the select edge; data for word step-1 is on the bus.
    assign wr_idx = WI_W'(int'(fill_ch) * K2 + int'(step) - 1);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= SELECT;
            rr_ptr     <= '0;
            fill_ch    <= '0;
            step       <= '0;
            mem_rd_o   <= 1'b0;
            mem_addr_o <= ADDR_WIDTH'(BASE_ADDR);
            for (int c = 0; c < N_CHANNELS; c++) begin
                kernel_valid_o[c] <= 1'b0;
                kernel_index_o[c] <= '0;
                hold_q[c]         <= 1'b0;
            end
            for (int w = 0; w < N_CHANNELS * K2; w++) begin
                kernel_o[w] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                hold_q[c] <= hold_kernel_i[c];
                if (kernel_valid_o[c] && hold_q[c] && !hold_kernel_i[c]) begin
                    kernel_valid_o[c] <= 1'b0;
                    kernel_index_o[c] <= (kernel_index_o[c] == IX_W'(N_KERNELS - 1)) ?
                                         '0 : kernel_index_o[c] + 1'b1;
                end
            end

            case (state)
                SELECT: begin
                    if (enable_i && pick_ok) begin
                        fill_ch    <= pick;
                        rr_ptr     <= (pick == CH_W'(N_CHANNELS - 1)) ? '0 : pick + 1'b1;
                        step       <= '0;
                        mem_rd_o   <= 1'b1;
                        mem_addr_o <= pick_addr;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    step <= step + 1'b1;
                    if (step < ST_W'(K2 - 1)) begin
                        mem_addr_o <= mem_addr_o + 1'b1;
                    end else begin
                        mem_rd_o <= 1'b0;
                    end
                    if (step != '0) begin
                        kernel_o[wr_idx] <= mem_data_i;
                    end
                    if (step == ST_W'(K2)) begin
                        kernel_valid_o[fill_ch] <= 1'b1;
                        state                   <= SELECT;
                    end
                end
                default: state <= SELECT;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_kernel_loader.sv
// Bench for conv_kernel_loader: directed vector table, hand sequences for
// enable gating and mid-fetch reset, then random traffic against a timeline model.
module tb_conv_kernel_loader;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int NC   = 2;
    localparam int NK   = 2;
    localparam int KS   = 3;
    localparam int K2   = KS * KS;
    localparam int BASE = 0;
    localparam int IW   = $clog2(NK) + 1;

    logic           clock_i = 1'b0;
    logic           reset_i;
    logic           enable_i;
    logic           hold_kernel_i [NC];
    logic [DW-1:0]  mem_data_i = '0;
    logic           mem_rd_o;
    logic [AW-1:0]  mem_addr_o;
    logic           kernel_valid_o [NC];
    logic [DW-1:0]  kernel_o [NC*K2];
    logic [IW-1:0]  kernel_index_o [NC];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit check_en = 1'b0;

    conv_kernel_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CHANNELS(NC),
        .N_KERNELS(NK), .KERNEL_SIZE(KS), .BASE_ADDR(BASE)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .hold_kernel_i(hold_kernel_i), .mem_data_i(mem_data_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .kernel_valid_o(kernel_valid_o), .kernel_o(kernel_o),
        .kernel_index_o(kernel_index_o)
    );

    always #5 clock_i = ~clock_i;
    always @(posedge clock_i) cyc++;

    // Weight memory: word a holds a+100, one cycle read latency.
    always @(posedge clock_i) if (mem_rd_o) mem_data_i <= DW'(mem_addr_o) + 32'd100;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int slot_addr(input int k, input int c);
        return (BASE + (k * NC + c) * K2) % 65536;
    endfunction

    // Reference model: a fill is a timeline of edges counted from its select edge.
    bit            m_valid [NC];
    int            m_index [NC];
    bit            m_hprev [NC];
    logic [DW-1:0] m_words [NC*K2];
    int            m_rr, m_ch, m_age;

    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < NC; c++) begin
                m_valid[c] = 1'b0; m_index[c] = 0; m_hprev[c] = 1'b0;
            end
            for (int w = 0; w < NC * K2; w++) m_words[w] = '0;
            m_rr = 0; m_ch = 0; m_age = -1;
        end else begin
            bit pv [NC];
            bit found;
            int c2;
            pv = m_valid;
            for (int c = 0; c < NC; c++) begin
                if (pv[c] && m_hprev[c] && !hold_kernel_i[c]) begin
                    m_valid[c] = 1'b0;
                    m_index[c] = (m_index[c] + 1) % NK;
                end
                m_hprev[c] = hold_kernel_i[c];
            end
            if (m_age >= 0) begin
                m_age++;
                if (m_age >= 2)
                    m_words[m_ch*K2 + m_age - 2] =
                        DW'(slot_addr(m_index[m_ch], m_ch) + m_age - 2 + 100);
                if (m_age == K2 + 1) begin
                    m_valid[m_ch] = 1'b1;
                    m_age = -1;
                end
            end else if (enable_i) begin
                found = 1'b0;
                for (int j = 0; j < NC; j++) begin
                    c2 = (m_rr + j) % NC;
                    if (!found && !pv[c2]) begin
                        found = 1'b1; m_ch = c2; m_age = 0; m_rr = (c2 + 1) % NC;
                    end
                end
            end
        end
    end

    always @(negedge clock_i) begin
        if (check_en && !reset_i) begin
            int bad, first;
            bit exp_rd;
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("model_valid%0d", c), kernel_valid_o[c], m_valid[c]);
                chk($sformatf("model_index%0d", c), int'(kernel_index_o[c]), m_index[c]);
            end
            exp_rd = (m_age >= 0) && (m_age < K2);
            chk("model_rd", mem_rd_o, exp_rd);
            if (exp_rd)
                chk("model_addr", int'(mem_addr_o), (slot_addr(m_index[m_ch], m_ch) + m_age) % 65536);
            bad = 0; first = 0;
            for (int w = 0; w < NC * K2; w++)
                if (kernel_o[w] !== m_words[w]) begin
                    if (bad == 0) first = w;
                    bad++;
                end
            chk($sformatf("model_words(first bad %0d)", first), bad, 0);
        end
    end

    typedef struct {
        int cycles; bit en; bit h0; bit h1;
        bit v0; bit v1; int i0; int i1; bit rd; int addr;
    } vec_t;

    function automatic vec_t mk(int cy, bit en, bit h0, bit h1, bit v0, bit v1,
                                int i0, int i1, bit rd, int addr);
        vec_t v;
        v.cycles = cy; v.en = en; v.h0 = h0; v.h1 = h1; v.v0 = v0; v.v1 = v1;
        v.i0 = i0; v.i1 = i1; v.rd = rd; v.addr = addr;
        return v;
    endfunction

    task automatic check_words(input int c, input int first, input string name);
        for (int i = 0; i < K2; i++)
            chk($sformatf("%s_w%0d", name, i), int'(kernel_o[c*K2 + i]), first + i);
    endtask

    task automatic wait_valid(input int c, input int limit, input string name);
        int n;
        n = 0;
        while (kernel_valid_o[c] !== 1'b1 && n < limit) begin
            @(negedge clock_i);
            n++;
        end
        chk(name, kernel_valid_o[c], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   n, rdc, bad;
        bit   hit;

        tbl.push_back(mk( 1, 1, 0, 0,  0, 0, 0, 0,  1,  0));
        tbl.push_back(mk( 9, 1, 0, 0,  0, 0, 0, 0,  0,  0));
        tbl.push_back(mk( 1, 1, 0, 0,  1, 0, 0, 0,  0,  0));
        tbl.push_back(mk( 1, 1, 0, 0,  1, 0, 0, 0,  1,  9));
        tbl.push_back(mk(10, 1, 0, 0,  1, 1, 0, 0,  0,  0));
        tbl.push_back(mk( 5, 1, 0, 0,  1, 1, 0, 0,  0,  0));
        tbl.push_back(mk( 1, 1, 1, 0,  1, 1, 0, 0,  0,  0));
        tbl.push_back(mk( 1, 1, 0, 0,  0, 1, 1, 0,  0,  0));
        tbl.push_back(mk( 1, 1, 0, 0,  0, 1, 1, 0,  1, 18));
        tbl.push_back(mk(10, 1, 0, 0,  1, 1, 1, 0,  0,  0));
        tbl.push_back(mk( 1, 1, 0, 1,  1, 1, 1, 0,  0,  0));
        tbl.push_back(mk( 1, 1, 0, 0,  1, 0, 1, 1,  0,  0));
        tbl.push_back(mk(11, 1, 0, 0,  1, 1, 1, 1,  0,  0));
        tbl.push_back(mk( 1, 1, 0, 1,  1, 1, 1, 1,  0,  0));
        tbl.push_back(mk( 1, 1, 0, 0,  1, 0, 1, 0,  0,  0));
        tbl.push_back(mk( 1, 1, 0, 0,  1, 0, 1, 0,  1,  9));
        tbl.push_back(mk(10, 1, 0, 0,  1, 1, 1, 0,  0,  0));
        tbl.push_back(mk(20, 1, 1, 1,  1, 1, 1, 0,  0,  0));

        reset_i = 1'b1; enable_i = 1'b0;
        hold_kernel_i[0] = 1'b0; hold_kernel_i[1] = 1'b0;
        repeat (2) @(negedge clock_i);
        chk("rst_valid0", kernel_valid_o[0], 0);
        chk("rst_valid1", kernel_valid_o[1], 0);
        chk("rst_index1", int'(kernel_index_o[1]), 0);
        chk("rst_rd", mem_rd_o, 0);
        chk("rst_addr", int'(mem_addr_o), BASE);
        bad = 0;
        for (int w = 0; w < NC * K2; w++) if (kernel_o[w] !== '0) bad++;
        chk("rst_words_nonzero", bad, 0);

        reset_i = 1'b0;
        check_en = 1'b1;
        for (int r = 0; r < tbl.size(); r++) begin
            enable_i = tbl[r].en;
            hold_kernel_i[0] = tbl[r].h0;
            hold_kernel_i[1] = tbl[r].h1;
            repeat (tbl[r].cycles) @(negedge clock_i);
            chk($sformatf("row%0d_v0", r), kernel_valid_o[0], tbl[r].v0);
            chk($sformatf("row%0d_v1", r), kernel_valid_o[1], tbl[r].v1);
            chk($sformatf("row%0d_i0", r), int'(kernel_index_o[0]), tbl[r].i0);
            chk($sformatf("row%0d_i1", r), int'(kernel_index_o[1]), tbl[r].i1);
            chk($sformatf("row%0d_rd", r), mem_rd_o, tbl[r].rd);
            if (tbl[r].rd) chk($sformatf("row%0d_addr", r), int'(mem_addr_o), tbl[r].addr);
            if (r == 4)  check_words(1, 109, "fill1");
            if (r == 9)  check_words(0, 118, "refill0");
            if (r == 9)  check_words(1, 109, "keep1");
            if (r == 16) check_words(1, 109, "wrap1");
        end

        // Consume slot 0 with enable low, then pulse hold while the slot is empty.
        enable_i = 1'b0; hold_kernel_i[0] = 1'b0;
        @(negedge clock_i);
        chk("gate_consume_i0", int'(kernel_index_o[0]), 0);
        chk("gate_consume_v0", kernel_valid_o[0], 0);
        hold_kernel_i[0] = 1'b1; @(negedge clock_i);
        hold_kernel_i[0] = 1'b0; @(negedge clock_i);
        chk("empty_pulse_i0", int'(kernel_index_o[0]), 0);
        rdc = 0;
        repeat (20) begin @(negedge clock_i); rdc += int'(mem_rd_o); end
        chk("gated_rd_cycles", rdc, 0);
        chk("gated_v0", kernel_valid_o[0], 0);

        // Enable for one select, then drop it mid-fetch; the fill must still finish.
        enable_i = 1'b1;
        @(negedge clock_i);
        chk("gate_sel_rd", mem_rd_o, 1);
        chk("gate_sel_addr", int'(mem_addr_o), 0);
        rdc = 1; n = 0;
        while (kernel_valid_o[0] !== 1'b1 && n < 20) begin
            if (n == 3) enable_i = 1'b0;
            @(negedge clock_i);
            rdc += int'(mem_rd_o);
            n++;
        end
        chk("drop_en_valid0", kernel_valid_o[0], 1);
        chk("drop_en_rd_cycles", rdc, 9);
        check_words(0, 100, "drop_en");

        hold_kernel_i[1] = 1'b0;
        @(negedge clock_i);
        chk("gate2_v1", kernel_valid_o[1], 0);
        chk("gate2_i1", int'(kernel_index_o[1]), 1);
        rdc = 0;
        repeat (20) begin @(negedge clock_i); rdc += int'(mem_rd_o); end
        chk("gate2_rd_cycles", rdc, 0);
        enable_i = 1'b1;
        wait_valid(1, 30, "gate2_refill_v1");
        check_words(1, 127, "k1c1");

        // Reset in the middle of a fetch (word 4 of kernel 1, channel 0).
        hold_kernel_i[0] = 1'b1; @(negedge clock_i);
        hold_kernel_i[0] = 1'b0; @(negedge clock_i);
        chk("pre_rst_i0", int'(kernel_index_o[0]), 1);
        hit = 1'b0; n = 0;
        while (!hit && n < 20) begin
            @(negedge clock_i);
            hit = mem_rd_o && (mem_addr_o == AW'(22));
            n++;
        end
        chk("reach_word4", hit, 1);
        #2 reset_i = 1'b1;
        #1;
        chk("midrst_v0", kernel_valid_o[0], 0);
        chk("midrst_v1", kernel_valid_o[1], 0);
        chk("midrst_i0", int'(kernel_index_o[0]), 0);
        chk("midrst_i1", int'(kernel_index_o[1]), 0);
        chk("midrst_rd", mem_rd_o, 0);
        chk("midrst_addr", int'(mem_addr_o), BASE);
        @(negedge clock_i);
        #2 reset_i = 1'b0;
        @(negedge clock_i);
        chk("restart_rd", mem_rd_o, 1);
        chk("restart_addr", int'(mem_addr_o), BASE);
        wait_valid(0, 20, "restart_v0");
        check_words(0, 100, "restart");

        // Random enable and hold traffic; the model checker covers every cycle.
        for (int t = 0; t < 3000; t++) begin
            enable_i = ($urandom_range(9) != 0);
            for (int c = 0; c < NC; c++)
                if ($urandom_range(5) == 0) hold_kernel_i[c] = ~hold_kernel_i[c];
            @(negedge clock_i);
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
